// File: rtl/seq_signed_divider.sv
// Sequential radix-2 restoring signed divider: one quotient bit per clock on
// magnitudes, with a single sign-fixup cycle. Quotient truncates, remainder takes the dividend's sign.
module seq_signed_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgnq_q, sgnq_d;
  logic             sgnr_q, sgnr_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;

  // The stored partial remainder is always below the divisor (<= 2^(WIDTH-1)),
  // so only the shifted value needs the extra bit; its difference fits WIDTH+1 signed bits.
  logic [WIDTH:0] shift_s;
  logic [WIDTH:0] trial_s;

  assign shift_s = {rem_q, dvd_q[WIDTH-1]};
  assign trial_s = shift_s - {1'b0, dsr_q};

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state, iteration and result-fixup logic
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          sgnr_d = a[WIDTH-1];
          if (b == '0) begin
            dvd_d   = a;
            dz_d    = 1'b1;
            state_d = FIX;
          end else begin
            dvd_d   = a[WIDTH-1] ? -a : a;
            dsr_d   = b[WIDTH-1] ? -b : b;
            sgnq_d  = a[WIDTH-1] ^ b[WIDTH-1];
            rem_d   = '0;
            cnt_d   = CW'(WIDTH);
            dz_d    = 1'b0;
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (trial_s[WIDTH]) begin
          rem_d = shift_s[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end else begin
          rem_d = trial_s[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end else begin
          state_d = CALC;
        end
      end
      FIX: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
        if (dz_q) begin
          quot_d = '1;
          rmd_d  = dvd_q;
          dbz_d  = 1'b1;
        end else begin
          quot_d = sgnq_q ? -dvd_q : dvd_q;
          rmd_d  = sgnr_q ? -rem_q : rem_q;
          dbz_d  = 1'b0;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider: vector table plus random vectors
// through a result scoreboard, with hand-written busy/back-to-back/reset sequences.
module tb_seq_signed_divider;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  always #5 clk = ~clk;

  seq_signed_divider #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
  } vec_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic chk(input bit ok, input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_run++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t   e;
    longint sa, sd;
    if (bv == '0) begin
      e.q = '1; e.r = av; e.dz = 1'b1;
    end else begin
      sa = longint'($signed(av));
      sd = longint'($signed(bv));
      e.q = W'(sa / sd); e.r = W'(sa % sd); e.dz = 1'b0;
    end
    return e;
  endfunction

  function automatic vec_t mkv(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
    vec_t v;
    v.a = av; v.b = bv; v.e.q = q; v.e.r = r; v.e.dz = dz;
    return v;
  endfunction

  // Drives start now (caller sits just after an edge), then follows handshake to done.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input exp_t e,
                        input int poke, input string name);
    int           k, lat;
    bit           hs_ok;
    exp_t         want;
    logic [W-1:0] pq, pr;
    logic         pdz;
    lat = (bv == '0) ? 1 : W + 1;
    start = 1'b1; a = av; b = bv;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    pq = quotient; pr = remainder; pdz = div_by_zero;
    hs_ok = (busy === 1'b1) && (done === 1'b0);
    k = 0;
    do begin
      if (k == poke) begin
        start = 1'b1; a = 32'd1; b = 32'd1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      k++;
      if (done !== 1'b1 && (busy !== 1'b1 || quotient !== pq || remainder !== pr || div_by_zero !== pdz))
        hs_ok = 1'b0;
      if (done === 1'b1 && busy !== 1'b0) hs_ok = 1'b0;
    end while (done !== 1'b1 && k < lat + 10);
    chk(done === 1'b1 && k == lat, {name, " latency"}, W'(k), W'(lat));
    chk(hs_ok, {name, " busy/hold"}, {31'd0, hs_ok}, 32'd1);
    want = sb.pop_front();
    chk(done === 1'b1 && quotient === want.q, {name, " quotient"}, quotient, want.q);
    chk(done === 1'b1 && remainder === want.r, {name, " remainder"}, remainder, want.r);
    chk(done === 1'b1 && div_by_zero === want.dz, {name, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, want.dz});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         tbl[14];
    logic [W-1:0] ra, rb;
    bit           saw;

    tbl[0]  = mkv(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    tbl[1]  = mkv(-32'sd100, 32'd7, -32'sd14, -32'sd2, 1'b0);
    tbl[2]  = mkv(32'd100, -32'sd7, -32'sd14, 32'd2, 1'b0);
    tbl[3]  = mkv(-32'sd100, -32'sd7, 32'd14, -32'sd2, 1'b0);
    tbl[4]  = mkv(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    tbl[5]  = mkv(32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0);
    tbl[6]  = mkv(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    tbl[7]  = mkv(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    tbl[8]  = mkv(32'd7, 32'd100, 32'd0, 32'd7, 1'b0);
    tbl[9]  = mkv(32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 1'b0);
    tbl[10] = mkv(32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, 1'b0);
    tbl[11] = mkv(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    tbl[12] = mkv(32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1);
    tbl[13] = mkv(32'd0, 32'd5, 32'd0, 32'd0, 1'b0);

    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    #2;
    chk(busy === 1'b0, "reset busy", {31'd0, busy}, 32'd0);
    chk(done === 1'b0, "reset done", {31'd0, done}, 32'd0);
    chk(quotient === '0, "reset quotient", quotient, 32'd0);
    chk(remainder === '0, "reset remainder", remainder, 32'd0);
    chk(div_by_zero === 1'b0, "reset dz", {31'd0, div_by_zero}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // Consecutive calls start in the done cycle, so these run back-to-back.
    for (int i = 0; i < 14; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].e, -1, $sformatf("vec%0d", i));

    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = (i % 3 == 0) ? W'($urandom_range(1, 255)) : $urandom;
      if (i == 5) rb = -rb;
      run_op(ra, rb, model(ra, rb), -1, $sformatf("rnd%0d", i));
    end

    // A second start and operand changes while busy are ignored.
    repeat (3) @(posedge clk);
    #1;
    run_op(32'd50, 32'd4, model(32'd50, 32'd4), 10, "busy_start");
    run_op(32'd81, -32'sd5, model(32'd81, -32'sd5), -1, "b2b_after_busy");

    // Asynchronous reset in the middle of an operation.
    start = 1'b1; a = -32'sd100; b = 32'd7;
    sb.push_back(model(a, b));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk(busy === 1'b0, "midreset busy", {31'd0, busy}, 32'd0);
    chk(done === 1'b0, "midreset done", {31'd0, done}, 32'd0);
    chk(quotient === '0, "midreset quotient", quotient, 32'd0);
    chk(remainder === '0, "midreset remainder", remainder, 32'd0);
    chk(div_by_zero === 1'b0, "midreset dz", {31'd0, div_by_zero}, 32'd0);
    sb.delete();
    @(negedge clk); reset = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) saw = 1'b1;
    end
    chk(!saw, "no done after reset", {31'd0, saw}, 32'd0);
    run_op(32'd100, 32'd7, model(32'd100, 32'd7), -1, "after_reset");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
